syncfifo_ctrl: RTL and testbench
================================

# syncfifo_ctrl

Single-clock FIFO controller that sequences the team's dual-port RAM (`fifomem`) as a synchronous FIFO. It owns the write and read pointers, gates write enables, and produces registered full, empty, almost-full and almost-empty flags plus an occupancy count. It sits beside one `fifomem` instance: it drives the RAM's write enable, write address, full input and read address, while data flows directly between the client and the RAM.

## Interface

Parameters:
- `ADDR_W`, default 4: RAM address width; `DEPTH = 2**ADDR_W` entries.
- `AFULL_TH`, default `DEPTH-2`: `o_aFull` asserts when count ≥ `AFULL_TH`; legal range 1..DEPTH.
- `AEMPTY_TH`, default 2: `o_aEmpty` asserts when count ≤ `AEMPTY_TH`; legal range 0..DEPTH-1.

Ports:
- `i_clk`, input, 1: sole clock; the same clock also drives the `fifomem` `i_wClk`.
- `i_rstN`, input, 1: **asynchronous, active-low reset**.
- `i_push`, input, 1: write request; data is presented to the RAM's `i_wData` in the same cycle.
- `i_pop`, input, 1: read request; consumes the word currently on the RAM's `o_rData`.
- `o_memWEn`, output, 1: to the RAM's `i_wClkEn`; equals `i_push & !o_full`.
- `o_memWAddr`, output, ADDR_W: to the RAM's `i_wAddr`; equals `wPtr[ADDR_W-1:0]`.
- `o_memFull`, output, 1: to the RAM's `i_wFull`; equals `o_full`.
- `o_memRAddr`, output, ADDR_W: to the RAM's `i_rAddr`; equals `rPtr[ADDR_W-1:0]`.
- `o_full`, output, 1: registered full flag.
- `o_empty`, output, 1: registered empty flag.
- `o_aFull`, output, 1: registered almost-full flag.
- `o_aEmpty`, output, 1: registered almost-empty flag.
- `o_count`, output, ADDR_W+1: registered occupancy, 0..DEPTH.
- `o_overflow`, output, 1: sticky error flag; present only when `SYNCFIFO_ERRFLAGS_EN` is defined.
- `o_underflow`, output, 1: sticky error flag; present only when `SYNCFIFO_ERRFLAGS_EN` is defined.
- `i_errClr`, input, 1: synchronous clear of both sticky error flags; present only when `SYNCFIFO_ERRFLAGS_EN` is defined.

## Operation

- Pointers `wPtr` and `rPtr` are ADDR_W+1 bits wide. The MSB is the wrap bit, and pointers wrap naturally modulo 2·DEPTH.
- **Push acceptance:** `pushOk = i_push & !o_full`. On `pushOk`, `wPtr` increments.
- **Pop acceptance:** `popOk = i_pop & !o_empty`. On `popOk`, `rPtr` increments.
- **Full and empty:**
  - Empty when `wPtr == rPtr`.
  - Full when the low ADDR_W bits are equal and the MSBs differ.
- **Count:** `wPtr - rPtr`, computed modulo 2^(ADDR_W+1).
- **Flag registration:** all flags and the count are computed from the next-state pointers and registered, so they are never one cycle stale.
- **Push while full** is dropped, even if a pop is accepted in the same cycle. This is consistent with the RAM gating writes on `i_wFull`.
- **Pop while empty** is dropped, even if a push is accepted in the same cycle. There is no fall-through bypass.
- **Simultaneous push and pop, neither blocked:** both pointers advance, and count and flags are unchanged.
- **Read data:** valid on the RAM's `o_rData` combinationally whenever `!o_empty`. The client samples it in the same cycle it asserts `i_pop`.
- **Reset mid-operation:** pointers return to 0 immediately and the FIFO becomes empty. RAM contents are not cleared and become irrelevant.

## Timing

- **Reset values:**
  - `o_empty = 1`, `o_aEmpty = 1`.
  - `o_full = 0`, `o_aFull = 0` (given `AFULL_TH ≥ 1`).
  - `o_count = 0`, both addresses 0.
  - Error flags 0.
  - `o_memWEn = i_push`.
- **Push latency:** a word pushed at edge N appears on `o_rData` after edge N, so it is poppable in cycle N+1. Push-to-pop latency is 1 cycle.
- **Flag and count update:** the cycle after the edge that accepts the operation.
- **Combinational outputs:** `o_memWEn` is combinational from `i_push` and registered `o_full`. There is no other combinational input-to-output path.

## Configuration

- `SYNCFIFO_ERRFLAGS_EN` defined:
  - `o_overflow` sets on `i_push & o_full`.
  - `o_underflow` sets on `i_pop & o_empty`.
  - Both remain set until `i_errClr` or reset.
  - A set event in the same cycle as `i_errClr` wins.
- `SYNCFIFO_ERRFLAGS_EN` undefined: the two error flags, `i_errClr` and their logic are absent. Dropped requests are silent.

## Structure

- Shared package `syncfifo_pkg` holds:
  - The pointer typedef, parameterised by ADDR_W.
  - The pure function `ptrDiff`.
  - Functions `isFull` and `isEmpty` on two pointers, reused by the future async variant.
- Sub-module `syncfifo_ptr`: one instance each for the write and read side. Each instance is a pointer register with an increment-enable input and returns the pointer and its next value.
- The `fifomem` instance lives in the wrapper `syncfifo`, not in the controller.

## Test plan

All scenarios use ADDR_W=4, DEPTH=16, AFULL_TH=14, AEMPTY_TH=2.

- **Reset:** assert `i_rstN=0` mid-stream holding count 5 → asynchronously `o_empty=1`, `o_count=0`, `o_memWAddr=o_memRAddr=0`.
- **Fill:** push 16 words 0x00..0x0F →
  - `o_aFull` rises after the 14th push.
  - `o_full` rises after the 16th push.
  - `o_count=16`.
  - A 17th push gives `o_memWEn=0` and `o_overflow=1` (macro on).
- **Drain:** from full, pop 16 → data 0x00..0x0F in order, `o_aEmpty` after count reaches 2, `o_empty` after the 16th pop; a 17th pop sets `o_underflow`.
- **Wrap-around:** 40 alternating push/pop bursts of 7 → pointer MSB toggles, data is always in order, and full/empty are never falsely asserted.
- **Simultaneous push+pop:**
  - At count 8: count stays 8.
  - At full: push dropped, count becomes 15.
  - At empty: pop dropped, count becomes 1.
- **Error clear:** with `o_overflow=1`, assert `i_errClr` with no push → `o_overflow=0` next cycle. With `i_errClr` and a push-at-full in the same cycle → flag stays 1.

Source files
------------

// File: rtl/syncfifo_pkg.sv
// rtl/syncfifo_pkg.sv - pointer type and wrap-bit pointer helpers shared by the sync and async FIFO controllers
package syncfifo_pkg;

  // Widest supported pointer; narrower pointers are zero-extended and masked to ADDR_W+1 bits.
  localparam int unsigned MAX_ADDR_W = 15;

  typedef logic [MAX_ADDR_W:0] ptr_t;

  function automatic ptr_t ptrMask(input int unsigned addrW);
    return (ptr_t'(1) << (addrW + 1)) - ptr_t'(1);
  endfunction

  function automatic ptr_t ptrDiff(input ptr_t a, input ptr_t b, input int unsigned addrW);
    return (a - b) & ptrMask(addrW);
  endfunction

  function automatic logic isEmpty(input ptr_t wPtr, input ptr_t rPtr, input int unsigned addrW);
    return ((wPtr ^ rPtr) & ptrMask(addrW)) == '0;
  endfunction

  // Full means the same slot on opposite laps: only the wrap bit differs.
  function automatic logic isFull(input ptr_t wPtr, input ptr_t rPtr, input int unsigned addrW);
    return ((wPtr ^ rPtr) & ptrMask(addrW)) == (ptr_t'(1) << addrW);
  endfunction

endpackage

// File: rtl/syncfifo_ptr.sv
// rtl/syncfifo_ptr.sv - wrap-bit FIFO pointer register with increment enable
module syncfifo_ptr
  import syncfifo_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rstN,
  input  logic              i_inc,
  output logic [ADDR_W:0]   o_ptr,
  output logic [ADDR_W:0]   o_ptrNext
);

  logic [ADDR_W:0] r_ptr;

  assign o_ptrNext = r_ptr + (ADDR_W + 1)'(i_inc);
  assign o_ptr     = r_ptr;

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) r_ptr <= '0;
    else         r_ptr <= o_ptrNext;
  end

endmodule

// File: rtl/syncfifo_ctrl.sv
// rtl/syncfifo_ctrl.sv - single-clock FIFO controller driving a fifomem dual-port RAM
// Optional sticky overflow/underflow flags with i_errClr when SYNCFIFO_ERRFLAGS_EN is defined.
module syncfifo_ctrl
  import syncfifo_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AFULL_TH  = (1 << ADDR_W) - 2,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic              i_clk,
  input  logic              i_rstN,
  input  logic              i_push,
  input  logic              i_pop,
`ifdef SYNCFIFO_ERRFLAGS_EN
  input  logic              i_errClr,
  output logic              o_overflow,
  output logic              o_underflow,
`endif
  output logic              o_memWEn,
  output logic [ADDR_W-1:0] o_memWAddr,
  output logic              o_memFull,
  output logic [ADDR_W-1:0] o_memRAddr,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_aFull,
  output logic              o_aEmpty,
  output logic [ADDR_W:0]   o_count
);

  localparam logic [ADDR_W:0] C_AFULL  = (ADDR_W + 1)'(AFULL_TH);
  localparam logic [ADDR_W:0] C_AEMPTY = (ADDR_W + 1)'(AEMPTY_TH);

  logic            r_full;
  logic            r_empty;
  logic            r_aFull;
  logic            r_aEmpty;
  logic [ADDR_W:0] r_count;

  logic            w_pushOk;
  logic            w_popOk;
  logic [ADDR_W:0] w_wPtr;
  logic [ADDR_W:0] w_wPtrNext;
  logic [ADDR_W:0] w_rPtr;
  logic [ADDR_W:0] w_rPtrNext;
  logic [ADDR_W:0] w_countNext;
  logic            w_fullNext;
  logic            w_emptyNext;

  // Blocked requests are dropped outright, independent of the opposite side.
  assign w_pushOk = i_push & ~r_full;
  assign w_popOk  = i_pop & ~r_empty;

  syncfifo_ptr #(.ADDR_W(ADDR_W)) u_wPtr (
    .i_clk     (i_clk),
    .i_rstN    (i_rstN),
    .i_inc     (w_pushOk),
    .o_ptr     (w_wPtr),
    .o_ptrNext (w_wPtrNext)
  );

  syncfifo_ptr #(.ADDR_W(ADDR_W)) u_rPtr (
    .i_clk     (i_clk),
    .i_rstN    (i_rstN),
    .i_inc     (w_popOk),
    .o_ptr     (w_rPtr),
    .o_ptrNext (w_rPtrNext)
  );

  // Flags come from next-state pointers so they are registered without a cycle of lag.
  assign w_countNext = (ADDR_W + 1)'(ptrDiff(ptr_t'(w_wPtrNext), ptr_t'(w_rPtrNext), ADDR_W));
  assign w_fullNext  = isFull(ptr_t'(w_wPtrNext), ptr_t'(w_rPtrNext), ADDR_W);
  assign w_emptyNext = isEmpty(ptr_t'(w_wPtrNext), ptr_t'(w_rPtrNext), ADDR_W);

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_aFull  <= 1'b0;
      r_aEmpty <= 1'b1;
      r_count  <= '0;
    end else begin
      r_full   <= w_fullNext;
      r_empty  <= w_emptyNext;
      r_aFull  <= (w_countNext >= C_AFULL);
      r_aEmpty <= (w_countNext <= C_AEMPTY);
      r_count  <= w_countNext;
    end
  end

  assign o_memWEn   = w_pushOk;
  assign o_memWAddr = ADDR_W'(w_wPtr);
  assign o_memFull  = r_full;
  assign o_memRAddr = ADDR_W'(w_rPtr);
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_aFull    = r_aFull;
  assign o_aEmpty   = r_aEmpty;
  assign o_count    = r_count;

`ifdef SYNCFIFO_ERRFLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // A new error event outranks a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (i_push & r_full) | (r_overflow & ~i_errClr);
      r_underflow <= (i_pop & r_empty) | (r_underflow & ~i_errClr);
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`endif

endmodule

// File: tb/tb_syncfifo_ctrl.sv
// tb/tb_syncfifo_ctrl.sv - directed self-checking bench for syncfifo_ctrl with a behavioural RAM
module tb_syncfifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       mem_wen;
  logic [3:0] mem_waddr;
  logic       mem_full;
  logic [3:0] mem_raddr;
  logic       full;
  logic       empty;
  logic       afull;
  logic       aempty;
  logic [4:0] count;
`ifdef SYNCFIFO_ERRFLAGS_EN
  logic       err_clr = 1'b0;
  logic       overflow;
  logic       underflow;
`endif

  logic [7:0] mem [16];
  logic [7:0] rdata;
  logic [7:0] exp_q [$];
  int         n_total = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  syncfifo_ctrl #(.ADDR_W(4), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
    .i_clk       (clk),
    .i_rstN      (rst_n),
    .i_push      (push),
    .i_pop       (pop),
`ifdef SYNCFIFO_ERRFLAGS_EN
    .i_errClr    (err_clr),
    .o_overflow  (overflow),
    .o_underflow (underflow),
`endif
    .o_memWEn    (mem_wen),
    .o_memWAddr  (mem_waddr),
    .o_memFull   (mem_full),
    .o_memRAddr  (mem_raddr),
    .o_full      (full),
    .o_empty     (empty),
    .o_aFull     (afull),
    .o_aEmpty    (aempty),
    .o_count     (count)
  );

  always @(posedge clk) begin
    if (mem_wen && !mem_full) mem[mem_waddr] <= wdata;
  end
  assign rdata = mem[mem_raddr];

  task automatic drive(input logic p, input logic q, input logic [7:0] d);
    push = p; pop = q; wdata = d;
    #1;
  endtask

  task automatic tick;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
`ifdef SYNCFIFO_ERRFLAGS_EN
    err_clr = 1'b0;
`endif
  endtask

  task automatic do_reset;
    @(negedge clk); rst_n = 1'b0;
    #1 rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0; push = 1'b1;
    #2;
    n_total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else n_pass++;
    n_total++; if (aempty !== 1'b1) $display("FAIL reset_aempty got %b exp 1", aempty); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else n_pass++;
    n_total++; if (afull !== 1'b0) $display("FAIL reset_afull got %b exp 0", afull); else n_pass++;
    n_total++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_total++; if (mem_waddr !== 4'd0 || mem_raddr !== 4'd0) $display("FAIL reset_addr got w%0d r%0d exp 0 0", mem_waddr, mem_raddr); else n_pass++;
    n_total++; if (mem_wen !== 1'b1) $display("FAIL reset_wen_follows_push got %b exp 1", mem_wen); else n_pass++;
`ifdef SYNCFIFO_ERRFLAGS_EN
    n_total++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL reset_errflags got %b%b exp 00", overflow, underflow); else n_pass++;
`endif
    push = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'(8'h10 + i)); tick;
    end
    n_total++; if (count !== 5'd5) $display("FAIL reset_pre_count got %0d exp 5", count); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (empty !== 1'b1) $display("FAIL reset_async_empty got %b exp 1", empty); else n_pass++;
    n_total++; if (count !== 5'd0) $display("FAIL reset_async_count got %0d exp 0", count); else n_pass++;
    n_total++; if (mem_waddr !== 4'd0 || mem_raddr !== 4'd0) $display("FAIL reset_async_addr got w%0d r%0d exp 0 0", mem_waddr, mem_raddr); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_fill;
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 1'b0, 8'(k - 1)); exp_q.push_back(8'(k - 1)); tick;
      n_total++; if (count !== 5'(k)) $display("FAIL fill_count[%0d] got %0d exp %0d", k, count, k); else n_pass++;
      n_total++; if (afull !== (k >= 14)) $display("FAIL fill_afull[%0d] got %b exp %b", k, afull, (k >= 14)); else n_pass++;
      n_total++; if (full !== (k == 16)) $display("FAIL fill_full[%0d] got %b exp %b", k, full, (k == 16)); else n_pass++;
      n_total++; if (empty !== 1'b0) $display("FAIL fill_empty[%0d] got %b exp 0", k, empty); else n_pass++;
    end
    drive(1'b1, 1'b0, 8'hAA);
    n_total++; if (mem_wen !== 1'b0) $display("FAIL fill_wen_at_full got %b exp 0", mem_wen); else n_pass++;
    tick;
    n_total++; if (count !== 5'd16) $display("FAIL fill_count_after_drop got %0d exp 16", count); else n_pass++;
`ifdef SYNCFIFO_ERRFLAGS_EN
    n_total++; if (overflow !== 1'b1) $display("FAIL fill_overflow got %b exp 1", overflow); else n_pass++;
`endif
  endtask

  task automatic test_drain;
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, 8'h00);
      n_total++; if (rdata !== 8'(k)) $display("FAIL drain_data[%0d] got %h exp %h", k, rdata, 8'(k)); else n_pass++;
      void'(exp_q.pop_front());
      tick;
      n_total++; if (count !== 5'(15 - k)) $display("FAIL drain_count[%0d] got %0d exp %0d", k, count, 15 - k); else n_pass++;
      n_total++; if (aempty !== ((15 - k) <= 2)) $display("FAIL drain_aempty[%0d] got %b exp %b", k, aempty, ((15 - k) <= 2)); else n_pass++;
      n_total++; if (empty !== (k == 15)) $display("FAIL drain_empty[%0d] got %b exp %b", k, empty, (k == 15)); else n_pass++;
      n_total++; if (full !== 1'b0) $display("FAIL drain_full[%0d] got %b exp 0", k, full); else n_pass++;
    end
    drive(1'b0, 1'b1, 8'h00); tick;
    n_total++; if (count !== 5'd0 || empty !== 1'b1) $display("FAIL drain_extra_pop got count %0d empty %b exp 0 1", count, empty); else n_pass++;
`ifdef SYNCFIFO_ERRFLAGS_EN
    n_total++; if (underflow !== 1'b1) $display("FAIL drain_underflow got %b exp 1", underflow); else n_pass++;
`endif
  endtask

  task automatic test_wrap;
    int wr_seq = 0;
    int rd_seq = 0;
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < 7; i++) begin
        if (b % 2 == 0) begin
          n_total++; if (mem_waddr !== 4'(wr_seq)) $display("FAIL wrap_waddr[%0d] got %0d exp %0d", wr_seq, mem_waddr, wr_seq % 16); else n_pass++;
          drive(1'b1, 1'b0, 8'(wr_seq + 8'h40)); wr_seq++; tick;
          n_total++; if (full !== 1'b0 || empty !== 1'b0) $display("FAIL wrap_push_flags[%0d] got full %b empty %b exp 0 0", wr_seq, full, empty); else n_pass++;
        end else begin
          n_total++; if (mem_raddr !== 4'(rd_seq)) $display("FAIL wrap_raddr[%0d] got %0d exp %0d", rd_seq, mem_raddr, rd_seq % 16); else n_pass++;
          drive(1'b0, 1'b1, 8'h00);
          n_total++; if (rdata !== 8'(rd_seq + 8'h40)) $display("FAIL wrap_data[%0d] got %h exp %h", rd_seq, rdata, 8'(rd_seq + 8'h40)); else n_pass++;
          rd_seq++; tick;
          n_total++; if (full !== 1'b0) $display("FAIL wrap_pop_full[%0d] got %b exp 0", rd_seq, full); else n_pass++;
        end
      end
      n_total++; if (count !== ((b % 2 == 0) ? 5'd7 : 5'd0)) $display("FAIL wrap_count[burst %0d] got %0d exp %0d", b, count, (b % 2 == 0) ? 7 : 0); else n_pass++;
      n_total++; if (empty !== (b % 2 == 1)) $display("FAIL wrap_empty[burst %0d] got %b exp %b", b, empty, (b % 2 == 1)); else n_pass++;
    end
  endtask

  task automatic test_simultaneous;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 8'(8'h80 + i)); exp_q.push_back(8'(8'h80 + i)); tick;
    end
    drive(1'b1, 1'b1, 8'hC0);
    n_total++; if (rdata !== 8'h80) $display("FAIL simul8_data got %h exp 80", rdata); else n_pass++;
    void'(exp_q.pop_front()); exp_q.push_back(8'hC0); tick;
    n_total++; if (count !== 5'd8) $display("FAIL simul8_count got %0d exp 8", count); else n_pass++;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 8'(8'hC0 + i)); exp_q.push_back(8'(8'hC0 + i)); tick;
    end
    n_total++; if (count !== 5'd16 || full !== 1'b1) $display("FAIL simul_prefull got count %0d full %b exp 16 1", count, full); else n_pass++;
    drive(1'b1, 1'b1, 8'hEE);
    n_total++; if (mem_wen !== 1'b0) $display("FAIL simul_full_wen got %b exp 0", mem_wen); else n_pass++;
    n_total++; if (rdata !== 8'h81) $display("FAIL simul_full_data got %h exp 81", rdata); else n_pass++;
    void'(exp_q.pop_front()); tick;
    n_total++; if (count !== 5'd15 || full !== 1'b0) $display("FAIL simul_full_count got count %0d full %b exp 15 0", count, full); else n_pass++;
`ifdef SYNCFIFO_ERRFLAGS_EN
    n_total++; if (overflow !== 1'b1) $display("FAIL simul_full_overflow got %b exp 1", overflow); else n_pass++;
`endif
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      n_total++; if (rdata !== exp_q[0]) $display("FAIL simul_drain_data[%0d] got %h exp %h", i, rdata, exp_q[0]); else n_pass++;
      void'(exp_q.pop_front()); tick;
    end
    n_total++; if (count !== 5'd0 || empty !== 1'b1) $display("FAIL simul_drained got count %0d empty %b exp 0 1", count, empty); else n_pass++;
    drive(1'b1, 1'b1, 8'h55); exp_q.push_back(8'h55); tick;
    n_total++; if (count !== 5'd1 || empty !== 1'b0) $display("FAIL simul_empty_count got count %0d empty %b exp 1 0", count, empty); else n_pass++;
    n_total++; if (rdata !== 8'h55) $display("FAIL simul_push_to_pop got %h exp 55", rdata); else n_pass++;
`ifdef SYNCFIFO_ERRFLAGS_EN
    n_total++; if (underflow !== 1'b1) $display("FAIL simul_empty_underflow got %b exp 1", underflow); else n_pass++;
`endif
  endtask

`ifdef SYNCFIFO_ERRFLAGS_EN
  task automatic test_err_clr;
    err_clr = 1'b1; tick;
    n_total++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL errclr_clear got %b%b exp 00", overflow, underflow); else n_pass++;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b0, 8'(8'h60 + i)); tick;
    end
    n_total++; if (full !== 1'b1) $display("FAIL errclr_prefull got %b exp 1", full); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL errclr_no_spurious got %b exp 0", overflow); else n_pass++;
    err_clr = 1'b1; drive(1'b1, 1'b0, 8'hFF); tick;
    n_total++; if (overflow !== 1'b1) $display("FAIL errclr_set_wins got %b exp 1", overflow); else n_pass++;
    n_total++; if (count !== 5'd16) $display("FAIL errclr_count got %0d exp 16", count); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
`ifdef SYNCFIFO_ERRFLAGS_EN
    test_err_clr();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
